// File: rtl/bp_cfg_loader.sv
// bp_cfg_loader: boot-time configuration sequencer.
// For each core it writes freeze=1, core_id, icache_mode and cce_mode.
// It then unfreezes every core in order and raises done_o.
// There is only ever one transaction outstanding on the config link.
// Optional feature macro: BP_CFG_LOADER_READBACK_EN. When it is defined, every
// write is followed by a read of the same register, and a mismatch sets error_o.
module bp_cfg_loader #(
    parameter int num_core_p       = 1,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 32,
    parameter int icache_mode_p    = 1,
    parameter int cce_mode_p       = 0,
    localparam int core_w_lp       = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    output logic                        cmd_v_o,
    input  logic                        cmd_ready_i,
    output logic [core_w_lp-1:0]        cmd_core_o,
    output logic [cfg_addr_width_p-1:0] cmd_addr_o,
    output logic [cfg_data_width_p-1:0] cmd_data_o,
    output logic                        cmd_we_o,
    input  logic                        resp_v_i,
    input  logic [cfg_data_width_p-1:0] resp_data_i,
    output logic                        resp_ready_o,
    output logic                        done_o,
    output logic                        error_o
);

    typedef enum logic [2:0] {
        S_RESET, S_SEND, S_WAIT, S_DONE
`ifdef BP_CFG_LOADER_READBACK_EN
        , S_RSEND, S_RWAIT
`endif
    } state_e;

    state_e                 state_q;
    logic [core_w_lp-1:0]   core_q, nxt_core;
    logic [1:0]             step_q, nxt_step;
    logic                   pass2_q, nxt_pass2;
    logic                   last_core, last_tx, adv, in_wait;

    // Register address for a (pass, step) position; pass 2 only touches freeze.
    function automatic logic [cfg_addr_width_p-1:0] step_addr(input logic p2, input logic [1:0] s);
        return p2 ? '0 : cfg_addr_width_p'(s);
    endfunction

    // Write data for a (pass, core, step) position.
    function automatic logic [cfg_data_width_p-1:0] step_data(input logic p2,
                                                               input logic [core_w_lp-1:0] c,
                                                               input logic [1:0] s);
        if (p2) return '0;
        case (s)
            2'd0:    return cfg_data_width_p'(1);
            2'd1:    return cfg_data_width_p'(c);
            2'd2:    return cfg_data_width_p'(icache_mode_p);
            default: return cfg_data_width_p'(cce_mode_p);
        endcase
    endfunction

    assign last_core = (core_q == core_w_lp'(num_core_p - 1));
    assign last_tx   = pass2_q && last_core;

`ifdef BP_CFG_LOADER_READBACK_EN
    logic we_q, err_q;
    assign cmd_we_o = we_q;
    assign error_o  = err_q;
    assign in_wait  = (state_q == S_WAIT) || (state_q == S_RWAIT);
    assign adv      = (state_q == S_RWAIT) && resp_v_i;
`else
    logic unused_resp_data;
    assign unused_resp_data = ^resp_data_i;
    assign cmd_we_o = 1'b1;
    assign error_o  = 1'b0;
    assign in_wait  = (state_q == S_WAIT);
    assign adv      = (state_q == S_WAIT) && resp_v_i;
`endif

    // Next position in the write sequence: steps 0..3 per core in pass 1, then one unfreeze per core.
    always_comb begin
        nxt_core  = core_q;
        nxt_step  = step_q;
        nxt_pass2 = pass2_q;
        if (!pass2_q) begin
            if (step_q == 2'd3) begin
                nxt_step = 2'd0;
                if (last_core) begin
                    nxt_core  = '0;
                    nxt_pass2 = 1'b1;
                end else begin
                    nxt_core = core_q + core_w_lp'(1);
                end
            end else begin
                nxt_step = step_q + 2'd1;
            end
        end else begin
            nxt_core = core_q + core_w_lp'(1);
        end
    end

    // Sequencer FSM; every output is registered.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_RESET;
            core_q       <= '0;
            step_q       <= '0;
            pass2_q      <= 1'b0;
            cmd_v_o      <= 1'b0;
            cmd_core_o   <= '0;
            cmd_addr_o   <= '0;
            cmd_data_o   <= '0;
            resp_ready_o <= 1'b0;
            done_o       <= 1'b0;
`ifdef BP_CFG_LOADER_READBACK_EN
            we_q         <= 1'b0;
            err_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_RESET: begin
                    state_q    <= S_SEND;
                    cmd_v_o    <= 1'b1;
                    cmd_core_o <= core_q;
                    cmd_addr_o <= step_addr(pass2_q, step_q);
                    cmd_data_o <= step_data(pass2_q, core_q, step_q);
`ifdef BP_CFG_LOADER_READBACK_EN
                    we_q       <= 1'b1;
`endif
                end
                S_SEND: begin
                    if (cmd_ready_i) begin
                        cmd_v_o      <= 1'b0;
                        resp_ready_o <= 1'b1;
                        state_q      <= S_WAIT;
                    end
                end
`ifdef BP_CFG_LOADER_READBACK_EN
                S_WAIT: begin
                    if (resp_v_i) begin
                        resp_ready_o <= 1'b0;
                        cmd_v_o      <= 1'b1;
                        we_q         <= 1'b0;
                        state_q      <= S_RSEND;
                    end
                end
                S_RSEND: begin
                    if (cmd_ready_i) begin
                        cmd_v_o      <= 1'b0;
                        resp_ready_o <= 1'b1;
                        state_q      <= S_RWAIT;
                    end
                end
                S_RWAIT: begin
                    // cmd_data_o still holds the value written; compare it to the readback.
                    if (resp_v_i && (resp_data_i != cmd_data_o)) err_q <= 1'b1;
                end
`endif
                default: ;
            endcase

            // A write (or readback) completes: move to the next write or finish.
            if (adv) begin
                resp_ready_o <= 1'b0;
                if (last_tx) begin
                    state_q <= S_DONE;
                    done_o  <= 1'b1;
                end else begin
                    state_q    <= S_SEND;
                    cmd_v_o    <= 1'b1;
                    core_q     <= nxt_core;
                    step_q     <= nxt_step;
                    pass2_q    <= nxt_pass2;
                    cmd_core_o <= nxt_core;
                    cmd_addr_o <= step_addr(nxt_pass2, nxt_step);
                    cmd_data_o <= step_data(nxt_pass2, nxt_core, nxt_step);
`ifdef BP_CFG_LOADER_READBACK_EN
                    we_q       <= 1'b1;
`endif
                end
            end
        end
    end

`ifndef SYNTHESIS
    a_cmd_hold: assert property (@(posedge clk_i) disable iff (reset_i)
        (cmd_v_o && !cmd_ready_i) |=> cmd_v_o);
    a_resp_in_wait: assert property (@(posedge clk_i) disable iff (reset_i)
        resp_v_i |-> in_wait)
        else $warning("bp_cfg_loader: response beat outside a wait state ignored");
    a_num_core: assert property (@(posedge clk_i) num_core_p >= 1);
`endif

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Directed bench for bp_cfg_loader. One instance is built with two cores and one with a
// single core. A shared responder drives whichever instance sel selects.
module tb_bp_cfg_loader;

`ifdef BP_CFG_LOADER_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        ready = 1'b0;
    logic        resp_v = 1'b0;
    logic [31:0] resp_data = '0;
    int          sel = 0;
    int          checks = 0;
    int          failures = 0;

    logic        a_v, a_we, a_rr, a_done, a_err, a_ready, a_resp_v;
    logic [0:0]  a_core;
    logic [15:0] a_addr;
    logic [31:0] a_data;
    logic        b_v, b_we, b_rr, b_done, b_err, b_ready, b_resp_v;
    logic [0:0]  b_core;
    logic [15:0] b_addr;
    logic [31:0] b_data;

    assign a_ready  = (sel == 0) && ready;
    assign a_resp_v = (sel == 0) && resp_v;
    assign b_ready  = (sel == 1) && ready;
    assign b_resp_v = (sel == 1) && resp_v;

    bp_cfg_loader #(.num_core_p(2)) dut_a (
        .clk_i(clk), .reset_i(reset), .cmd_v_o(a_v), .cmd_ready_i(a_ready),
        .cmd_core_o(a_core), .cmd_addr_o(a_addr), .cmd_data_o(a_data), .cmd_we_o(a_we),
        .resp_v_i(a_resp_v), .resp_data_i(resp_data), .resp_ready_o(a_rr),
        .done_o(a_done), .error_o(a_err));

    bp_cfg_loader #(.num_core_p(1)) dut_b (
        .clk_i(clk), .reset_i(reset), .cmd_v_o(b_v), .cmd_ready_i(b_ready),
        .cmd_core_o(b_core), .cmd_addr_o(b_addr), .cmd_data_o(b_data), .cmd_we_o(b_we),
        .resp_v_i(b_resp_v), .resp_data_i(resp_data), .resp_ready_o(b_rr),
        .done_o(b_done), .error_o(b_err));

    logic        v, we, rr, done, err;
    logic [0:0]  core;
    logic [15:0] addr;
    logic [31:0] data;
    always_comb begin
        if (sel == 1) begin
            v = b_v; we = b_we; rr = b_rr; done = b_done; err = b_err;
            core = b_core; addr = b_addr; data = b_data;
        end else begin
            v = a_v; we = a_we; rr = a_rr; done = a_done; err = a_err;
            core = a_core; addr = a_addr; data = a_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; ready = 1'b0; resp_v = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    // One transaction: j is the index within the sequence (reads interleave when readback is built in).
    task automatic do_tx(input int j, input int ncore, input int stall, input int rdelay,
                         input bit spur, input bit bad, input bit rst_after, output bit ok);
        int wi, ec, ea, ed, total;
        bit is_rd;
        ok = 1'b0;
        total = (RB ? 10 : 5) * ncore;
        wi = RB ? j / 2 : j;
        is_rd = (RB == 1) && (j % 2 == 1);
        if (wi < 4 * ncore) begin
            ec = wi / 4; ea = wi % 4;
            ed = (ea == 0) ? 1 : (ea == 1) ? ec : (ea == 2) ? 1 : 0;
        end else begin
            ec = wi - 4 * ncore; ea = 0; ed = 0;
        end
        for (int k = 0; k < 40 && !v; k++) step();
        checks++;
        if (v !== 1'b1) begin
            failures++;
            $display("FAIL cmd_timeout tx=%0d: cmd_v=%b required 1", j, v);
            return;
        end
        checks++;
        if (core !== 1'(ec) || addr !== 16'(ea) || (!is_rd && data !== 32'(ed))) begin
            failures++;
            $display("FAIL cmd_fields tx=%0d: core=%0d addr=%0h data=%0h required core=%0d addr=%0h data=%0h",
                     j, core, addr, data, ec, ea, ed);
        end
        checks++;
        if (we !== (is_rd ? 1'b0 : 1'b1)) begin
            failures++;
            $display("FAIL cmd_we tx=%0d: we=%b required %b", j, we, !is_rd);
        end
        if (spur) begin
            resp_v = 1'b1;
            step();
            resp_v = 1'b0;
            checks++;
            if (v !== 1'b1 || rr !== 1'b0 || addr !== 16'(ea) || core !== 1'(ec)) begin
                failures++;
                $display("FAIL spurious_resp tx=%0d: v=%b rr=%b addr=%0h required v=1 rr=0 addr=%0h",
                         j, v, rr, addr, ea);
            end
        end
        for (int s = 0; s < stall; s++) begin
            step();
            checks++;
            if (v !== 1'b1 || addr !== 16'(ea) || data !== 32'(ed)) begin
                failures++;
                $display("FAIL stall_hold tx=%0d cyc=%0d: v=%b addr=%0h data=%0h required v=1 addr=%0h data=%0h",
                         j, s, v, addr, data, ea, ed);
            end
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
        checks++;
        if (v !== 1'b0 || rr !== 1'b1) begin
            failures++;
            $display("FAIL accept tx=%0d: v=%b resp_ready=%b required v=0 resp_ready=1", j, v, rr);
        end
        if (rst_after) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            checks++;
            if (v !== 1'b0 || rr !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
                addr !== 16'h0 || data !== 32'h0 || core !== 1'b0) begin
                failures++;
                $display("FAIL mid_reset: v=%b rr=%b done=%b err=%b addr=%0h data=%0h required all 0",
                         v, rr, done, err, addr, data);
            end
            return;
        end
        for (int d = 1; d < rdelay; d++) begin
            step();
            checks++;
            if (v !== 1'b0 || rr !== 1'b1) begin
                failures++;
                $display("FAIL wait_idle tx=%0d: v=%b rr=%b required v=0 rr=1", j, v, rr);
            end
        end
        resp_v = 1'b1;
        resp_data = bad ? 32'h5 : (is_rd ? 32'(ed) : 32'h0);
        step();
        resp_v = 1'b0;
        resp_data = '0;
        if (bad) begin
            checks++;
            if (err !== 1'b1) begin
                failures++;
                $display("FAIL readback_error tx=%0d: error=%b required 1", j, err);
            end
        end
        checks++;
        if (j == total - 1) begin
            if (done !== 1'b1 || v !== 1'b0) begin
                failures++;
                $display("FAIL done tx=%0d: done=%b v=%b required done=1 v=0", j, done, v);
            end
        end else if (v !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back tx=%0d: v=%b done=%b required v=1 done=0", j, v, done);
        end
        ok = 1'b1;
    endtask

    task automatic run_seq(input int ncore, input int stall_j, input int stall_n, input int rdelay,
                           input int spur_j, input int bad_j, input int rst_j);
        bit ok;
        int total;
        total = (RB ? 10 : 5) * ncore;
        for (int j = 0; j < total; j++) begin
            do_tx(j, ncore, (j == stall_j) ? stall_n : 0, rdelay, j == spur_j, j == bad_j, j == rst_j, ok);
            if (!ok) return;
        end
    endtask

    task automatic test_reset();
        sel = 0;
        reset = 1'b1; ready = 1'b0; resp_v = 1'b0;
        step(); step(); step();
        checks++;
        if (a_v !== 1'b0 || a_rr !== 1'b0 || a_done !== 1'b0 || a_err !== 1'b0 ||
            a_addr !== 16'h0 || a_data !== 32'h0 || a_core !== 1'b0 ||
            b_v !== 1'b0 || b_rr !== 1'b0 || b_done !== 1'b0 || b_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: a_v=%b a_rr=%b a_done=%b b_v=%b b_done=%b required all 0",
                     a_v, a_rr, a_done, b_v, b_done);
        end
        reset = 1'b0;
        step();
        checks++;
        if (a_v !== 1'b1 || a_addr !== 16'h0 || a_data !== 32'h1) begin
            failures++;
            $display("FAIL first_cmd: v=%b addr=%0h data=%0h required v=1 addr=0 data=1", a_v, a_addr, a_data);
        end
    endtask

    task automatic test_basic();
        sel = 0;
        apply_reset();
        run_seq(2, -1, 0, 1, -1, -1, -1);
        // Ready while idle in DONE must not start anything.
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (v !== 1'b0 || done !== 1'b1 || err !== 1'b0) begin
                failures++;
                $display("FAIL done_idle: v=%b done=%b err=%b required v=0 done=1 err=0", v, done, err);
            end
        end
        ready = 1'b0;
    endtask

    task automatic test_backpressure();
        sel = 0;
        apply_reset();
        run_seq(2, RB ? 4 : 2, 5, 1, -1, -1, -1);
    endtask

    task automatic test_spurious();
        sel = 0;
        apply_reset();
        run_seq(2, -1, 0, 7, 1, -1, -1);
    endtask

    task automatic test_reset_mid();
        sel = 0;
        apply_reset();
        run_seq(2, -1, 0, 1, -1, -1, RB ? 10 : 5);
        run_seq(2, -1, 0, 1, -1, -1, -1);
    endtask

    task automatic test_single_core();
        sel = 1;
        apply_reset();
        run_seq(1, -1, 0, 1, -1, RB ? 3 : -1, -1);
        checks++;
        if (err !== 1'(RB)) begin
            failures++;
            $display("FAIL single_error: error=%b required %0d", err, RB);
        end
        sel = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_spurious();
        test_reset_mid();
        test_single_core();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
